alu_operand_loader: RTL

Sequential operand-entry front end for the ALU on the DE2 board. It debounces the push buttons and steps through a four-phase entry sequence. Each phase latches one switch value into a registered ALU port: port A, then port B, then the opcode. It then captures the ALU result and flags into a hold register for display. It replaces direct switch-to-port wiring, so every ALU input is stable and changes only on a deliberate button press.

---
 rtl/alu_operand_loader_pkg.sv | 24 ++
 rtl/alu_operand_loader_if.sv | 25 ++
 rtl/alu_operand_loader_key_debounce.sv | 64 ++++++
 rtl/alu_operand_loader.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_operand_loader_pkg.sv
// alu_operand_loader_pkg: shared types, state codes and key indices for the operand loader.
// Types: word_t (ALU port width), aluop_t (opcode), loader_state_t (entry phases).
// Constants: KEY_STEP, KEY_CLEAR index the active-low push buttons.
package alu_operand_loader_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  aluop_t;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } loader_state_t;

    localparam int unsigned KEY_STEP  = 0;
    localparam int unsigned KEY_CLEAR = 1;

    function automatic word_t sign_ext(input logic fill, input logic [15:0] v);
        return {{16{fill}}, v};
    endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: ALU operand/result bundle between the loader and the ALU.
// master (loader): drives portA, portB, aluop; reads outport and the three flags.
// slave  (ALU):    reads operands and opcode; drives outport and flags.
interface alu_operand_loader_if;
    import alu_operand_loader_pkg::*;

    word_t  portA;
    word_t  portB;
    aluop_t aluop;
    word_t  outport;
    logic   overflow_flag;
    logic   zero_flag;
    logic   negative_flag;

    modport master (
        output portA, portB, aluop,
        input  outport, overflow_flag, zero_flag, negative_flag
    );

    modport slave (
        input  portA, portB, aluop,
        output outport, overflow_flag, zero_flag, negative_flag
    );

endinterface

// File: rtl/alu_operand_loader_key_debounce.sv
// key_debounce: two-flop synchronizer plus press detector for one active-low key.
// Ports: clk, rst (sync, active-high), key_i (raw key), press_o (one-cycle press pulse).
// ALU_LOADER_DEBOUNCE_EN defined: pulse after DEBOUNCE_CYCLES continuous low samples;
// undefined: pulse is the synchronized falling edge and DEBOUNCE_CYCLES is ignored.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic press_o
);

    logic [1:0] sync_q;
    logic       level;
    logic       press_q;

    assign level   = sync_q[1];
    assign press_o = press_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], key_i};
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int unsigned W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W-1:0] LIM = W'(DEBOUNCE_CYCLES);

    logic [W-1:0] cnt_q, cnt_d;
    logic         press_d;

    // Counter saturates at LIM so a held key yields exactly one pulse.
    always_comb begin
        cnt_d   = level ? '0 : (cnt_q == LIM) ? LIM : cnt_q + 1'b1;
        press_d = !level && (cnt_q == LIM - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end
`else
    localparam int unsigned unused_cycles = DEBOUNCE_CYCLES;

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            level_q <= level;
            press_q <= level_q && !level;
        end
    end
`endif

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: button-stepped entry of ALU operands, opcode and result capture.
// Ports: CLK, RST (sync, active-high); KEY[3:0] active-low (0 = step, 1 = clear);
// SW[17:0] (15:0 value, 16 fill bit); alu (master: portA, portB, aluop out; outport, flags in);
// display_word (hex display value), flags_held {neg, zero, ovf}, state_code (LED state).
// Optional macro ALU_LOADER_DEBOUNCE_EN enables the debounce counters in key_debounce.
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            KEY,
    input  logic [17:0]           SW,
    alu_operand_loader_if.master  alu,
    output word_t                 display_word,
    output logic [2:0]            flags_held,
    output logic [2:0]            state_code
);

    logic [3:0]    press;
    logic [16:0]   sw_s1_q, sw_s2_q;
    word_t         ext;
    logic          step, clr;
    loader_state_t state_q;
    word_t         a_q, b_q, res_q;
    aluop_t        op_q;
    logic [2:0]    flags_q;
    logic          unused_in;

    genvar k;
    for (k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (CLK),
            .rst     (RST),
            .key_i   (KEY[k]),
            .press_o (press[k])
        );
    end

    assign unused_in = ^{press[3:2], SW[17]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= SW[16:0];
            sw_s2_q <= sw_s1_q;
        end
    end

    assign ext  = sign_ext(sw_s2_q[16], sw_s2_q[15:0]);
    assign step = press[KEY_STEP];
    assign clr  = press[KEY_CLEAR];

    // Clear shares the reset path so it always wins over a same-cycle step.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                LOAD_A:  if (step) begin a_q <= ext; state_q <= LOAD_B; end
                LOAD_B:  if (step) begin b_q <= ext; state_q <= LOAD_OP; end
                LOAD_OP: if (step) begin op_q <= sw_s2_q[3:0]; state_q <= EXEC; end
                EXEC: begin
                    res_q   <= alu.outport;
                    flags_q <= {alu.negative_flag, alu.zero_flag, alu.overflow_flag};
                    state_q <= SHOW;
                end
                SHOW:    if (step) state_q <= LOAD_A;
                default: state_q <= LOAD_A;
            endcase
        end
    end

    assign alu.portA  = a_q;
    assign alu.portB  = b_q;
    assign alu.aluop  = op_q;
    assign flags_held = flags_q;
    assign state_code = state_q;

    // In EXEC res_q still holds the previous result; the new one lands entering SHOW.
    always_comb begin
        display_word = (state_q == LOAD_OP) ? {28'b0, sw_s2_q[3:0]} :
                       (state_q == EXEC || state_q == SHOW) ? res_q : ext;
    end

endmodule
